// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: one req/ack transaction at a time.
// The stage drives the request side; the memory returns a one-cycle ack with read data.
interface mem_access_stage_if #(
    parameter int ADDR_W = 10
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: decodes the memory op, runs one req/ack transaction,
// formats store lanes / extends load data, and stalls the pipeline until done.
module mem_access_stage #(
    parameter int ADDR_W         = 10,
    parameter int CTRL_MEMR_BIT  = 3,
    parameter int CTRL_MEMW_BIT  = 4,
    parameter int CTRL_SIZE_LSB  = 5,
    parameter int CTRL_UNS_BIT   = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         MEM_ALU_R,
    input  logic [31:0]         MEM_CTRL,
    input  logic [31:0]         MEM_RF_B,
    input  logic                MEM_HALT,
    mem_access_stage_if.master  dmem,
    output logic                mem_stall,
    output logic [31:0]         MEM_LOAD_DATA,
    output logic                mem_misalign,
    output logic                mem_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Last counter value before abort: BUSY lasts at most TIMEOUT_CYCLES cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   f_store_be = 4'b0001 << lane;
            2'b01:   f_store_be = lane[1] ? 4'b1100 : 4'b0011;
            default: f_store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_store_wdata(input logic [1:0] size, input logic [31:0] b);
        case (size)
            2'b00:   f_store_wdata = {4{b[7:0]}};
            2'b01:   f_store_wdata = {2{b[15:0]}};
            default: f_store_wdata = b;
        endcase
    endfunction

    function automatic logic [31:0] f_load_fmt(input logic [1:0] size, input logic uns,
                                               input logic [1:0] lane, input logic [31:0] rd);
        logic [7:0]  v_b;
        logic [15:0] v_h;
        v_b = rd[8*lane +: 8];
        v_h = lane[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   f_load_fmt = uns ? {24'b0, v_b} : {{24{v_b[7]}}, v_b};
            2'b01:   f_load_fmt = uns ? {16'b0, v_h} : {{16{v_h[15]}}, v_h};
            default: f_load_fmt = rd;
        endcase
    endfunction

    logic       w_memr, w_memw, w_uns, w_half, w_word, w_op, w_access, w_we;
    logic [1:0] w_size, w_lane;
    logic       w_unused;

    assign w_memr   = MEM_CTRL[CTRL_MEMR_BIT];
    assign w_memw   = MEM_CTRL[CTRL_MEMW_BIT];
    assign w_size   = MEM_CTRL[CTRL_SIZE_LSB +: 2];
    assign w_uns    = MEM_CTRL[CTRL_UNS_BIT];
    assign w_lane   = MEM_ALU_R[1:0];
    assign w_half   = (w_size == 2'b01);
    assign w_word   = w_size[1];
    assign w_op     = (w_memr | w_memw) & ~MEM_HALT;
    assign w_we     = w_memw & ~w_memr;
    assign w_unused = ^{MEM_CTRL, MEM_ALU_R};

    assign mem_misalign = w_op & ((w_half & w_lane[0]) | (w_word & (|w_lane)));
    assign w_access     = w_op & ~mem_misalign;

    state_t            r_state, w_next;
    logic              r_req, r_we, r_timeout, r_is_load, r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata, r_load;
    logic [1:0]        r_size, r_lane;
    logic [7:0]        r_cnt;
    logic              w_launch, w_ack_done, w_to, w_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_launch   = 1'b0;
        w_ack_done = 1'b0;
        w_to       = 1'b0;
        w_count    = 1'b0;
        mem_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_stall = w_access;
                if (w_access) begin
                    w_launch = 1'b1;
                    w_next   = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                // Ack takes priority over an abort landing in the same cycle.
                if (dmem.dmem_ack) begin
                    w_ack_done = 1'b1;
                    w_next     = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_to   = 1'b1;
                    w_next = S_DONE;
                end else begin
                    w_count = 1'b1;
                end
            end
            // The pipeline advances out of DONE, so the op is never relaunched.
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_load    <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_is_load <= 1'b0;
            r_uns     <= 1'b0;
            r_size    <= '0;
            r_lane    <= '0;
        end else begin
            r_timeout <= w_to;
            if (w_launch) begin
                r_req     <= 1'b1;
                r_we      <= w_we;
                r_addr    <= MEM_ALU_R[ADDR_W+1:2];
                r_be      <= f_store_be(w_size, w_lane);
                r_wdata   <= f_store_wdata(w_size, MEM_RF_B);
                r_is_load <= w_memr;
                r_uns     <= w_uns;
                r_size    <= w_size;
                r_lane    <= w_lane;
                r_cnt     <= '0;
            end
            if (w_count) r_cnt <= r_cnt + 8'd1;
            if (w_ack_done || w_to) r_req <= 1'b0;
            // Load result uses the format captured at launch, not the live control word.
            if (w_ack_done && r_is_load) r_load <= f_load_fmt(r_size, r_uns, r_lane, dmem.dmem_rdata);
            if (w_to && r_is_load) r_load <= '0;
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign MEM_LOAD_DATA   = r_load;
    assign mem_timeout     = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed + randomized bench for mem_access_stage with an arithmetic reference model.
module tb_mem_access_stage;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_ALU_R, MEM_CTRL, MEM_RF_B;
    logic        MEM_HALT;
    logic        mem_stall, mem_misalign, mem_timeout;
    logic [31:0] MEM_LOAD_DATA;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_load = 32'h0;

    mem_access_stage_if #(.ADDR_W(10)) dmem_bus ();

    mem_access_stage dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_ALU_R    (MEM_ALU_R),
        .MEM_CTRL     (MEM_CTRL),
        .MEM_RF_B     (MEM_RF_B),
        .MEM_HALT     (MEM_HALT),
        .dmem         (dmem_bus),
        .mem_stall    (mem_stall),
        .MEM_LOAD_DATA(MEM_LOAD_DATA),
        .mem_misalign (mem_misalign),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input int size);
        return (size == 0) ? 1 : (size == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mk_ctrl(input bit memr, input bit memw, input int size, input bit uns);
        return (32'(memr) << 3) | (32'(memw) << 4) | (32'(size % 4) << 5) | (32'(uns) << 7);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input int size, input bit uns,
                                           input logic [31:0] rd);
        int n;
        longint unsigned full, r, v;
        n    = nbytes(size);
        full = 64'd1 << (8 * n);
        r    = 64'(rd);
        v    = (r >> (8 * (a % 4))) % full;
        if (!uns && v >= full / 2) v = v + (64'd1 << 32) - full;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_be(input logic [31:0] a, input int size);
        int n;
        n = nbytes(size);
        return ((32'd1 << n) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] b, input int size);
        int n;
        longint unsigned full, lane, acc;
        n    = nbytes(size);
        full = 64'd1 << (8 * n);
        lane = 64'(b) % full;
        acc  = 0;
        for (int i = 0; i < 4 / n; i++) acc = acc + (lane << (8 * n * i));
        return acc[31:0];
    endfunction

    // Called at a falling edge with the FSM idle; d = BUSY cycle carrying the ack, 0 = never.
    task automatic run_op(input bit memr, input bit memw, input int size, input bit uns,
                          input logic [31:0] a, input logic [31:0] b, input bit halt,
                          input logic [31:0] rd, input int d);
        int n, stalls, nb;
        bit op, mis, acc, to;
        logic [31:0] e_addr, e_be, e_wd;
        n      = nbytes(size);
        op     = (memr || memw) && !halt;
        mis    = op && ((a % n) != 0);
        acc    = op && !mis;
        e_addr = (a / 4) % 1024;
        e_be   = m_be(a, size);
        e_wd   = m_wdata(b, size);
        MEM_CTRL  = mk_ctrl(memr, memw, size, uns) | ($urandom & 32'hFFFF_FF07);
        MEM_ALU_R = a;
        MEM_RF_B  = b;
        MEM_HALT  = halt;
        #1;
        chk("misalign", 32'(mem_misalign), 32'(mis));
        if (!acc) begin
            chk("noacc_stall", 32'(mem_stall), 0);
            chk("noacc_req", 32'(dmem_bus.dmem_req), 0);
            @(posedge clk); @(negedge clk);
            chk("noacc_req_next", 32'(dmem_bus.dmem_req), 0);
            chk("noacc_load", MEM_LOAD_DATA, exp_load);
            return;
        end
        chk("idle_stall", 32'(mem_stall), 1);
        chk("idle_req", 32'(dmem_bus.dmem_req), 0);
        stalls = 1;
        @(posedge clk); @(negedge clk);
        to = (d == 0) || (d > TO);
        nb = to ? TO : d;
        for (int k = 1; k <= nb; k++) begin
            if (mem_stall) stalls++;
            if (k <= 2) begin
                chk("busy_req", 32'(dmem_bus.dmem_req), 1);
                chk("busy_addr", 32'(dmem_bus.dmem_addr), e_addr);
                chk("busy_be", 32'(dmem_bus.dmem_be), e_be);
                chk("busy_we", 32'(dmem_bus.dmem_we), 32'(memw && !memr));
                chk("busy_timeout", 32'(mem_timeout), 0);
                if (memw && !memr) chk("busy_wdata", dmem_bus.dmem_wdata, e_wd);
            end
            if (k == 1) begin
                MEM_CTRL  = $urandom;
                MEM_ALU_R = $urandom;
                MEM_RF_B  = $urandom;
            end
            if (k == nb && !to) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = rd;
            end
            @(posedge clk); @(negedge clk);
            dmem_bus.dmem_ack = 1'b0;
        end
        if (memr) exp_load = to ? 32'h0 : m_load(a, size, uns, rd);
        chk("done_stall", 32'(mem_stall), 0);
        chk("done_req", 32'(dmem_bus.dmem_req), 0);
        chk("done_timeout", 32'(mem_timeout), 32'(to));
        chk("done_load", MEM_LOAD_DATA, exp_load);
        chk("stall_cycles", 32'(stalls), 32'(1 + nb));
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = ~rd;
        @(posedge clk); @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        chk("after_req", 32'(dmem_bus.dmem_req), 0);
        chk("after_timeout", 32'(mem_timeout), 0);
        chk("after_load", MEM_LOAD_DATA, exp_load);
    endtask

    task automatic bubble();
        MEM_CTRL  = 32'h0;
        MEM_ALU_R = 32'h0;
        MEM_RF_B  = 32'h0;
        MEM_HALT  = 1'b0;
    endtask

    initial begin
        int size, kind, n;
        bit memr, memw, uns, halt;
        logic [31:0] a;
        reset = 1'b0;
        bubble();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dmem_bus.dmem_req), 0);
        chk("rst_we", 32'(dmem_bus.dmem_we), 0);
        chk("rst_addr", 32'(dmem_bus.dmem_addr), 0);
        chk("rst_be", 32'(dmem_bus.dmem_be), 0);
        chk("rst_wdata", dmem_bus.dmem_wdata, 0);
        chk("rst_load", MEM_LOAD_DATA, 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases from the datasheet examples.
        run_op(1, 0, 2, 0, 32'h10, 32'h0, 0, 32'h8000_00F0, 1);
        run_op(1, 0, 0, 0, 32'h13, 32'h0, 0, 32'h8012_3456, 1);
        chk("sbyte_load", MEM_LOAD_DATA, 32'hFFFF_FF80);
        run_op(1, 0, 0, 1, 32'h13, 32'h0, 0, 32'h8012_3456, 2);
        chk("ubyte_load", MEM_LOAD_DATA, 32'h0000_0080);
        run_op(0, 1, 1, 0, 32'h22, 32'h1234_ABCD, 0, 32'h5555_5555, 5);
        run_op(1, 0, 2, 0, 32'h06, 32'h0, 0, 32'h0, 1);
        run_op(1, 0, 1, 0, 32'h4F, 32'h0, 0, 32'h0, 1);
        run_op(1, 1, 1, 1, 32'h0000_0106, 32'h0, 0, 32'hBEEF_7FFF, 3);
        run_op(1, 0, 2, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'hCAFE_F00D, 1);
        run_op(0, 1, 2, 0, 32'h40, 32'h0, 1, 32'h0, 1);
        run_op(1, 0, 2, 0, 32'h20, 32'h0, 0, 32'h1111_2222, 0);
        run_op(1, 0, 1, 0, 32'h32, 32'h0, 0, 32'h8001_7FFF, TO);
        run_op(0, 1, 0, 0, 32'h81, 32'hA5A5_A53C, 0, 32'h0, 0);

        // Ack while idle must not disturb anything.
        bubble();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        dmem_bus.dmem_ack = 1'b0;
        chk("idle_ack_req", 32'(dmem_bus.dmem_req), 0);
        chk("idle_ack_load", MEM_LOAD_DATA, exp_load);

        // Randomized ops.
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 5);
            memr = (kind == 0) || (kind == 2) || (kind == 4);
            memw = (kind == 1) || (kind == 2) || (kind == 5);
            halt = ($urandom_range(0, 7) == 0);
            size = $urandom_range(0, 3);
            uns  = $urandom_range(0, 1);
            n    = nbytes(size);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
            run_op(memr, memw, size, uns, a, $urandom, halt, $urandom, $urandom_range(1, 6));
        end

        // Async reset while BUSY.
        run_op(1, 0, 2, 0, 32'h44, 32'h0, 0, 32'h7654_3210, 1);
        MEM_CTRL  = mk_ctrl(1, 0, 2, 0);
        MEM_ALU_R = 32'h48;
        MEM_HALT  = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("prerst_req", 32'(dmem_bus.dmem_req), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_bus.dmem_req), 0);
        chk("midrst_load", MEM_LOAD_DATA, 0);
        exp_load = 32'h0;
        bubble();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst_req", 32'(dmem_bus.dmem_req), 0);
        chk("postrst_stall", 32'(mem_stall), 0);
        run_op(0, 1, 0, 0, 32'h3, 32'h0000_00E7, 0, 32'h0, 2);

        bubble();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
